// File: rtl/falu_issue_ctrl.sv
// Issue/retire controller for the single-precision FALU: decodes RV32F ops, holds
// operands for a per-op multicycle window, captures the result and keeps sticky flags.
module falu_issue_ctrl #(
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 6,
    parameter int LAT_CMP    = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_funct7,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic [31:0] falu_a,
    output logic [31:0] falu_b,
    output logic [3:0]  falu_op,
    input  logic [31:0] falu_result,
    input  logic        falu_exception,
    input  logic        falu_overflow,
    input  logic        falu_underflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic [2:0]  fflags,
    input  logic        fflags_clr,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt;
    logic [3:0]  dec_op;
    logic        dec_legal;
    logic        accept, capture;
    logic [2:0]  flags_new;

    function automatic logic [7:0] lat_load(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: lat_load = 8'(LAT_ADDSUB - 1);
            4'd2:       lat_load = 8'(LAT_MUL - 1);
            4'd3:       lat_load = 8'(LAT_DIV - 1);
            default:    lat_load = 8'(LAT_CMP - 1);
        endcase
    endfunction

    always_comb begin
        dec_op    = 4'hF;
        dec_legal = 1'b0;
        case (req_funct7)
            7'b0000000: begin dec_op = 4'd0; dec_legal = 1'b1; end
            7'b0000100: begin dec_op = 4'd1; dec_legal = 1'b1; end
            7'b0001000: begin dec_op = 4'd2; dec_legal = 1'b1; end
            7'b0001100: begin dec_op = 4'd3; dec_legal = 1'b1; end
            7'b1010000: begin
                case (req_funct3)
                    3'b000:  begin dec_op = 4'd4; dec_legal = 1'b1; end
                    3'b001:  begin dec_op = 4'd5; dec_legal = 1'b1; end
                    3'b010:  begin dec_op = 4'd6; dec_legal = 1'b1; end
                    default: begin dec_op = 4'hF; dec_legal = 1'b0; end
                endcase
            end
            default: begin dec_op = 4'hF; dec_legal = 1'b0; end
        endcase
    end

    // Flush overrides both a new acceptance and a pending capture.
    assign accept    = (state == IDLE) && req_valid && dec_legal && !flush;
    assign capture   = (state == EXEC) && (cnt == 8'd0) && !flush;
    assign flags_new = {falu_exception, falu_overflow, falu_underflow};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (cnt == 8'd0) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == DONE);
        busy      = (state != IDLE);
        falu_op   = 4'hF;
        falu_a    = 32'd0;
        falu_b    = 32'd0;
        if (state == EXEC) begin
            falu_op = op_q;
            falu_a  = a_q;
            falu_b  = b_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            op_q      <= 4'hF;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rd_q      <= 5'd0;
            cnt       <= 8'd0;
            rsp_data  <= 32'd0;
            rsp_rd    <= 5'd0;
            rsp_flags <= 3'd0;
            fflags    <= 3'd0;
            illegal   <= 1'b0;
        end else begin
            state   <= state_next;
            illegal <= (state == IDLE) && req_valid && !dec_legal && !flush;
            if (accept) begin
                op_q <= dec_op;
                a_q  <= req_a;
                b_q  <= req_b;
                rd_q <= req_rd;
                cnt  <= lat_load(dec_op);
            end else if ((state == EXEC) && !flush && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end
            // Compare ops return only the predicate bit in bit 0.
            if (capture) begin
                rsp_data  <= (op_q >= 4'd4) ? {31'd0, falu_result[0]} : falu_result;
                rsp_rd    <= rd_q;
                rsp_flags <= flags_new;
            end
            if (!flush) begin
                if (capture)
                    fflags <= (fflags_clr ? 3'd0 : fflags) | flags_new;
                else if (fflags_clr)
                    fflags <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_falu_issue_ctrl.sv
// Directed bench for falu_issue_ctrl: a vector table of ops plus hand sequences
// for backpressure, flush, sticky-flag clear and reset in DONE.
`timescale 1ns/1ps
module tb_falu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid, req_ready;
    logic [6:0]  req_funct7;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic [31:0] falu_a, falu_b;
    logic [3:0]  falu_op;
    logic [31:0] falu_result;
    logic        falu_exception, falu_overflow, falu_underflow;
    logic        rsp_valid, rsp_ready;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_flags, fflags;
    logic        fflags_clr, illegal, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [2:0] fm;

    typedef struct {
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  flg;
        logic        legal;
        logic [3:0]  op;
        logic [31:0] data;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    falu_issue_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct7(req_funct7), .req_funct3(req_funct3), .req_rd(req_rd),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .falu_a(falu_a), .falu_b(falu_b), .falu_op(falu_op),
        .falu_result(falu_result), .falu_exception(falu_exception),
        .falu_overflow(falu_overflow), .falu_underflow(falu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .fflags(fflags),
        .fflags_clr(fflags_clr), .illegal(illegal), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Presents a request together with the result/flags the FALU model will return for it.
    task automatic apply_stimulus(input vec_t v);
        req_valid      = 1'b1;
        req_funct7     = v.f7;
        req_funct3     = v.f3;
        req_a          = v.a;
        req_b          = v.b;
        req_rd         = v.rd;
        falu_result    = v.res;
        {falu_exception, falu_overflow, falu_underflow} = v.flg;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int  cycles;
        logic held;
        apply_stimulus(v);
        tick();
        req_valid = 1'b0;
        if (!v.legal) begin
            check_output({tag, ".illegal"}, 32'(illegal), 32'd1);
            check_output({tag, ".op_idle"}, 32'(falu_op), 32'hF);
            check_output({tag, ".busy"}, 32'(busy), 32'd0);
            check_output({tag, ".ready"}, 32'(req_ready), 32'd1);
            tick();
            check_output({tag, ".illegal_clr"}, 32'(illegal), 32'd0);
        end else begin
            cycles = 0;
            held   = 1'b1;
            while (!rsp_valid && cycles < 20) begin
                if (falu_op !== v.op || falu_a !== v.a || falu_b !== v.b || req_ready !== 1'b0)
                    held = 1'b0;
                tick();
                cycles++;
            end
            check_output({tag, ".latency"}, 32'(cycles), 32'(v.lat));
            check_output({tag, ".held"}, 32'(held), 32'd1);
            check_output({tag, ".data"}, rsp_data, v.data);
            check_output({tag, ".rd"}, 32'(rsp_rd), 32'(v.rd));
            check_output({tag, ".flags"}, 32'(rsp_flags), 32'(v.flg));
            fm = fm | v.flg;
            check_output({tag, ".fflags"}, 32'(fflags), 32'(fm));
            check_output({tag, ".op_done"}, 32'(falu_op), 32'hF);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check_output({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
            check_output({tag, ".ready_back"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        int   cycles;
        logic bad;
        vec_t v;

        vecs[0] = '{7'b0000000, 3'b000, 32'h3FC00000, 32'h40100000, 5'd5, 32'h40700000, 3'b000, 1'b1, 4'd0, 32'h40700000, 2};
        vecs[1] = '{7'b0000100, 3'b000, 32'h40100000, 32'h3FC00000, 5'd6, 32'h3F400000, 3'b000, 1'b1, 4'd1, 32'h3F400000, 2};
        vecs[2] = '{7'b0001000, 3'b000, 32'h40000000, 32'h40400000, 5'd7, 32'h40C00000, 3'b010, 1'b1, 4'd2, 32'h40C00000, 3};
        vecs[3] = '{7'b0001100, 3'b000, 32'h40800000, 32'h40000000, 5'd8, 32'h40000000, 3'b000, 1'b1, 4'd3, 32'h40000000, 6};
        vecs[4] = '{7'b1010000, 3'b001, 32'h3F800000, 32'h40000000, 5'd9, 32'hABCDEF01, 3'b000, 1'b1, 4'd5, 32'h00000001, 1};
        vecs[5] = '{7'b1010000, 3'b001, 32'h40000000, 32'h3F800000, 5'd10, 32'h12345670, 3'b000, 1'b1, 4'd5, 32'h00000000, 1};
        vecs[6] = '{7'b1010000, 3'b000, 32'h3F800000, 32'h3F800000, 5'd11, 32'h00000001, 3'b100, 1'b1, 4'd4, 32'h00000001, 1};
        vecs[7] = '{7'b1010000, 3'b010, 32'h3F800000, 32'h40000000, 5'd12, 32'hFFFFFFFE, 3'b000, 1'b1, 4'd6, 32'h00000000, 1};
        vecs[8] = '{7'b0101100, 3'b000, 32'h3F800000, 32'h40000000, 5'd13, 32'h0, 3'b000, 1'b0, 4'hF, 32'h0, 0};
        vecs[9] = '{7'b1010000, 3'b011, 32'h3F800000, 32'h40000000, 5'd14, 32'h0, 3'b000, 1'b0, 4'hF, 32'h0, 0};

        RESET = 1'b1; req_valid = 1'b0; req_funct7 = '0; req_funct3 = '0; req_rd = '0;
        req_a = '0; req_b = '0; flush = 1'b0; falu_result = '0; falu_exception = 1'b0;
        falu_overflow = 1'b0; falu_underflow = 1'b0; rsp_ready = 1'b0; fflags_clr = 1'b0;
        fm = 3'b000;
        tick();
        tick();
        check_output("reset.op", 32'(falu_op), 32'hF);
        check_output("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.fflags", 32'(fflags), 32'd0);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < 10; i++)
            run_vector(vecs[i], $sformatf("vec%0d", i));

        // Sticky clear without a capture.
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        fm = 3'b000;
        check_output("clr.fflags", 32'(fflags), 32'd0);

        // Divide with backpressure; an add waits in req_valid until after the handshake.
        v = vecs[3];
        v.rd = 5'd9;
        apply_stimulus(v);
        tick();
        req_valid = 1'b0;
        wait_rsp(cycles);
        check_output("bp.latency", 32'(cycles), 32'd6);
        apply_stimulus(vecs[0]);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_rd !== 5'd9 ||
                rsp_flags !== 3'b000 || req_ready !== 1'b0)
                bad = 1'b1;
            tick();
        end
        check_output("bp.stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("bp.no_same_cycle", 32'(busy), 32'd0);
        check_output("bp.ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_output("bp.next_accept", 32'(falu_op), 32'd0);
        wait_rsp(cycles);
        check_output("bp.next_latency", 32'(cycles), 32'd2);
        check_output("bp.next_data", rsp_data, 32'h40700000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Flush on the third EXEC cycle of a divide; the flag on the bus must not be captured.
        apply_stimulus(vecs[3]);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        falu_overflow = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush.rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("flush.op", 32'(falu_op), 32'hF);
        check_output("flush.busy", 32'(busy), 32'd0);
        check_output("flush.fflags", 32'(fflags), 32'(fm));
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        check_output("flush.never_valid", 32'(bad), 32'd0);
        falu_overflow = 1'b0;

        // Reset while a multiply result waits in DONE.
        apply_stimulus(vecs[2]);
        tick();
        req_valid = 1'b0;
        wait_rsp(cycles);
        check_output("rst.reached_done", 32'(rsp_valid), 32'd1);
        check_output("rst.pre_fflags", 32'(fflags), 32'b010);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        fm = 3'b000;
        falu_overflow = 1'b0;
        check_output("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst.rsp_data", rsp_data, 32'd0);
        check_output("rst.rsp_rd", 32'(rsp_rd), 32'd0);
        check_output("rst.rsp_flags", 32'(rsp_flags), 32'd0);
        check_output("rst.fflags", 32'(fflags), 32'd0);
        check_output("rst.illegal", 32'(illegal), 32'd0);
        check_output("rst.op", 32'(falu_op), 32'hF);
        check_output("rst.falu_a", falu_a, 32'd0);
        check_output("rst.busy", 32'(busy), 32'd0);
        check_output("rst.ready", 32'(req_ready), 32'd1);
        run_vector(vecs[0], "post_rst_add");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/falu_issue_ctrl.md
Name: falu_issue_ctrl

Overview:
- Issue/retire controller on the initiator side of the single-precision floating-point ALU interface.
- Accepts decoded RV32F arithmetic and compare requests from the execute stage and translates them to the 4-bit FALU operation code.
- Holds operands stable on the FALU inputs for a per-operation multicycle window, then captures the result and flags into a response register for writeback.
- Keeps sticky exception/overflow/underflow flags for CSR read.

Parameters:
- LAT_ADDSUB, 2, cycles the FALU inputs are held for add/sub (min 1)
- LAT_MUL, 3, cycles held for multiply (min 1)
- LAT_DIV, 6, cycles held for divide (min 1)
- LAT_CMP, 1, cycles held for compares (min 1)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_funct7  in  7  instruction funct7
- req_funct3  in  3  instruction funct3
- req_rd  in  5  destination register
- req_a  in  32  operand A (IEEE-754 single)
- req_b  in  32  operand B
- flush  in  1  pipeline flush; drop in-flight op
- falu_a  out  32  FALU operand A
- falu_b  out  32  FALU operand B
- falu_op  out  4  FALU operation code
- falu_result  in  32  FALU output
- falu_exception  in  1  FALU Exception
- falu_overflow  in  1  FALU Overflow
- falu_underflow  in  1  FALU Underflow
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback accepts
- rsp_rd  out  5  destination register of result
- rsp_data  out  32  captured result
- rsp_flags  out  3  {exception, overflow, underflow} of this result
- fflags  out  3  sticky {exception, overflow, underflow}
- fflags_clr  in  1  clear sticky flags
- illegal  out  1  one-cycle pulse: unsupported encoding rejected
- busy  out  1  high in EXEC or DONE

Behaviour:
Decode, funct7/funct3 to falu_op:
- 0000000 -> 0 (add)
- 0000100 -> 1 (sub)
- 0001000 -> 2 (mul)
- 0001100 -> 3 (div)
- 1010000 with funct3 000 -> 4 (le), 001 -> 5 (lt), 010 -> 6 (eq)
- Anything else is illegal.

FSM states are IDLE, EXEC and DONE.
- IDLE:
  - req_ready=1.
  - On req_valid with a legal encoding: latch operands, op and rd; load counter = LAT(op)-1; go to EXEC.
  - On req_valid with an illegal encoding: illegal=1 for the next cycle; nothing is latched; stay in IDLE.
- EXEC:
  - req_ready=0.
  - falu_a, falu_b and falu_op are driven from the latched registers, constant for the whole state.
  - Counter decrements each cycle.
  - When counter==0: capture falu_result into rsp_data and {falu_exception, falu_overflow, falu_underflow} into rsp_flags; go to DONE.
- DONE:
  - rsp_valid=1; req_ready=0.
  - On rsp_ready: go to IDLE. The next request can be accepted in the following cycle, not the same cycle.
- Outside EXEC (IDLE and DONE): falu_op=4'hF (no unit selected), falu_a=falu_b=0.

Timing:
- A request accepted at edge N gives rsp_valid high after edge N+LAT(op).
- rsp_data, rsp_rd and rsp_flags stay stable while rsp_valid=1 and rsp_ready=0.

Compare ops:
- rsp_data = {31'b0, bit}. The bit comes from falu_result[0].

Sticky flags:
- Updated only at the capture edge.
- Next-state value = (fflags_clr ? 0 : fflags) | rsp_flags_new.
- fflags_clr without a capture clears the flags.

Flush (synchronous):
- Forces IDLE and rsp_valid=0 from any state; no capture occurs.
- fflags are unchanged. illegal is cleared.
- A flush takes priority over a req_valid or capture in the same cycle.

RESET (highest priority):
- State=IDLE.
- rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_flags=0, fflags=0, illegal=0.
- falu_op=4'hF, falu_a=falu_b=0, counter=0, busy=0.
- Reset mid-EXEC or mid-DONE discards the operation.

Test Plan:
- Add: funct7=0000000, a=0x3FC00000 (1.5), b=0x40100000 (2.25), rd=5 -> falu_op=0 held exactly 2 cycles; rsp_valid 2 cycles after accept, rsp_data=0x40700000 (3.75), rsp_rd=5, rsp_flags=0.
- Divide with backpressure: funct7=0001100, a=0x40800000 (4.0), b=0x40000000 (2.0), rsp_ready held low 4 cycles -> rsp_valid 6 cycles after accept, rsp_data=0x40000000 held stable until rsp_ready; req_ready=0 throughout; next request accepted the cycle after the handshake.
- Compare: funct7=1010000, funct3=001 (lt), a=0x3F800000 (1.0), b=0x40000000 (2.0) -> falu_op=5 for 1 cycle; rsp_data=0x00000001. Swapping the operands gives rsp_data=0x00000000.
- Illegal and flags: funct7=0101100 -> illegal pulses 1 cycle, state stays IDLE, falu_op stays 0xF. Then a multiply whose FALU model returns overflow=1 -> rsp_flags=3'b010, fflags=3'b010. Then fflags_clr -> fflags=0.
- Flush mid-op: start a divide, assert flush on the 3rd EXEC cycle -> IDLE next cycle, rsp_valid never asserts, fflags unchanged, falu_op=0xF.
- Reset mid-DONE: hold rsp_valid=1, assert RESET -> every output at its reset value after the edge; the next add completes normally.
